// File: rtl/sd_block_receiver.sv
// SD single-block read receiver: token hunt, data FIFO, trailing CRC16 check.
// Optional CRC checking is enabled by defining SD_BLOCK_CRC_CHECK_EN.
module sd_block_receiver #(
    parameter int unsigned BLOCK_LEN     = 512,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned TOKEN_TIMEOUT = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_busy,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic       o_out_valid,
    output logic [7:0] o_out_data,
    output logic       o_out_last,
    input  logic       i_out_ready,
    output logic       o_done,
    output logic       o_crc_err,
    output logic       o_token_err,
    output logic       o_timeout_err
);
    localparam int unsigned BCW = $clog2(BLOCK_LEN + 1);
    localparam int unsigned TCW = $clog2(TOKEN_TIMEOUT + 1);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BCW-1:0] LastIdx = BCW'(BLOCK_LEN - 1);
    localparam logic [TCW-1:0] ToLast  = TCW'(TOKEN_TIMEOUT - 1);
    localparam logic [CW-1:0]  Full    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StHunt, StData, StCrcHi, StCrcLo, StDrain, StFinish} state_t;

    state_t         r_state, w_state_d;
    logic [BCW-1:0] r_byte_cnt, w_byte_cnt_d;
    logic [TCW-1:0] r_to_cnt, w_to_cnt_d;
    logic           r_token_err, w_token_err_d;
    logic           r_timeout_err, w_timeout_err_d;

    logic [8:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_full, w_push, w_pop, w_last;

    assign w_full      = (r_count == Full);
    assign o_out_valid = (r_count != '0);
    assign w_pop       = o_out_valid & i_out_ready;
    assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr][7:0] : 8'h00;
    assign o_out_last  = o_out_valid & r_mem[r_rd_ptr][8];
    assign o_busy      = (r_state != StIdle) && (r_state != StFinish);
    assign o_token_err   = r_token_err;
    assign o_timeout_err = r_timeout_err;

`ifdef SD_BLOCK_CRC_CHECK_EN
    logic [15:0] r_crc, w_crc_d;
    logic [7:0]  r_crc_hi, w_crc_hi_d;
    logic        r_crc_err, w_crc_err_d;

    // XMODEM variant: poly 0x1021, MSB first, one whole byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    assign o_crc_err = r_crc_err;
`else
    assign o_crc_err = 1'b0;
`endif

    always_comb begin
        w_state_d       = r_state;
        w_byte_cnt_d    = r_byte_cnt;
        w_to_cnt_d      = r_to_cnt;
        w_token_err_d   = r_token_err;
        w_timeout_err_d = r_timeout_err;
`ifdef SD_BLOCK_CRC_CHECK_EN
        w_crc_d         = r_crc;
        w_crc_hi_d      = r_crc_hi;
        w_crc_err_d     = r_crc_err;
`endif
        o_in_ready = 1'b0;
        o_done     = 1'b0;
        w_push     = 1'b0;
        w_last     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d       = StHunt;
                    w_byte_cnt_d    = '0;
                    w_to_cnt_d      = '0;
                    w_token_err_d   = 1'b0;
                    w_timeout_err_d = 1'b0;
`ifdef SD_BLOCK_CRC_CHECK_EN
                    w_crc_d         = 16'h0000;
                    w_crc_err_d     = 1'b0;
`endif
                end
            end
            StHunt: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    if (i_in_data == 8'hFE) begin
                        w_state_d = StData;
                    end else if (i_in_data == 8'hFF) begin
                        w_to_cnt_d = r_to_cnt + 1'b1;
                        if (r_to_cnt == ToLast) begin
                            w_timeout_err_d = 1'b1;
                            w_state_d       = StFinish;
                        end
                    end else begin
                        w_token_err_d = 1'b1;
                        w_state_d     = StFinish;
                    end
                end
            end
            StData: begin
                // Full check deliberately ignores a same-cycle pop.
                o_in_ready = ~w_full;
                if (i_in_valid && !w_full) begin
                    w_push       = 1'b1;
                    w_last       = (r_byte_cnt == LastIdx);
                    w_byte_cnt_d = r_byte_cnt + 1'b1;
`ifdef SD_BLOCK_CRC_CHECK_EN
                    w_crc_d      = crc16_byte(r_crc, i_in_data);
`endif
                    if (w_last) w_state_d = StCrcHi;
                end
            end
            StCrcHi: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
`ifdef SD_BLOCK_CRC_CHECK_EN
                    w_crc_hi_d = i_in_data;
`endif
                    w_state_d = StCrcLo;
                end
            end
            StCrcLo: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
`ifdef SD_BLOCK_CRC_CHECK_EN
                    w_crc_err_d = ({r_crc_hi, i_in_data} != r_crc);
`endif
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (r_count == '0) w_state_d = StFinish;
            end
            StFinish: begin
                o_done    = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_byte_cnt    <= '0;
            r_to_cnt      <= '0;
            r_token_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
`ifdef SD_BLOCK_CRC_CHECK_EN
            r_crc         <= 16'h0000;
            r_crc_hi      <= 8'h00;
            r_crc_err     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_d;
            r_byte_cnt    <= w_byte_cnt_d;
            r_to_cnt      <= w_to_cnt_d;
            r_token_err   <= w_token_err_d;
            r_timeout_err <= w_timeout_err_d;
`ifdef SD_BLOCK_CRC_CHECK_EN
            r_crc         <= w_crc_d;
            r_crc_hi      <= w_crc_hi_d;
            r_crc_err     <= w_crc_err_d;
`endif
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: output is gated by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_last, i_in_data};
    end
endmodule

// File: tb/tb_sd_block_receiver.sv
// Directed bench for sd_block_receiver: a 9-byte/short-timeout instance and a
// 512-byte instance share one stimulus driver selected by sel.
module tb_sd_block_receiver;
`ifdef SD_BLOCK_CRC_CHECK_EN
    localparam logic CrcOn = 1'b1;
`else
    localparam logic CrcOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic a_busy, a_in_ready, a_out_valid, a_out_last, a_done, a_crc_err, a_token_err, a_timeout_err;
    logic b_busy, b_in_ready, b_out_valid, b_out_last, b_done, b_crc_err, b_token_err, b_timeout_err;
    logic [7:0] a_out_data, b_out_data;

    logic busy, in_ready, out_valid, out_last, done, crc_err, token_err, timeout_err;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    sd_block_receiver #(.BLOCK_LEN(9), .FIFO_DEPTH(16), .TOKEN_TIMEOUT(8)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start & ~sel), .o_busy(a_busy),
        .i_in_valid(in_valid & ~sel), .i_in_data(in_data), .o_in_ready(a_in_ready),
        .o_out_valid(a_out_valid), .o_out_data(a_out_data), .o_out_last(a_out_last),
        .i_out_ready(out_ready & ~sel), .o_done(a_done), .o_crc_err(a_crc_err),
        .o_token_err(a_token_err), .o_timeout_err(a_timeout_err)
    );

    sd_block_receiver #(.BLOCK_LEN(512), .FIFO_DEPTH(16), .TOKEN_TIMEOUT(1024)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start & sel), .o_busy(b_busy),
        .i_in_valid(in_valid & sel), .i_in_data(in_data), .o_in_ready(b_in_ready),
        .o_out_valid(b_out_valid), .o_out_data(b_out_data), .o_out_last(b_out_last),
        .i_out_ready(out_ready & sel), .o_done(b_done), .o_crc_err(b_crc_err),
        .o_token_err(b_token_err), .o_timeout_err(b_timeout_err)
    );

    assign busy        = sel ? b_busy        : a_busy;
    assign in_ready    = sel ? b_in_ready    : a_in_ready;
    assign out_valid   = sel ? b_out_valid   : a_out_valid;
    assign out_data    = sel ? b_out_data    : a_out_data;
    assign out_last    = sel ? b_out_last    : a_out_last;
    assign done        = sel ? b_done        : a_done;
    assign crc_err     = sel ? b_crc_err     : a_crc_err;
    assign token_err   = sel ? b_token_err   : a_token_err;
    assign timeout_err = sel ? b_timeout_err : a_timeout_err;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int fed = 0;
    logic seen_valid = 1'b0;
    logic done_with_valid = 1'b0;
    logic [7:0] rx_q[$];
    logic       last_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after posedge, so mid-cycle values predict the next edge.
    always @(negedge clk) begin
        if (out_valid) seen_valid <= 1'b1;
        if (out_valid && out_ready) begin
            rx_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (out_valid) done_with_valid <= 1'b1;
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        last_q.delete();
        done_cnt = 0;
        seen_valid = 1'b0;
        done_with_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_stall", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, done_cnt, 1);
    endtask

    task automatic run_good(input string tag, input logic [7:0] crc_lo, input logic exp_crc);
        int lasts = 0;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        repeat (3) send_byte(8'hFF);
        send_byte(8'hFE);
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
        send_byte(8'h31);
        send_byte(crc_lo);
        in_valid = 1'b0;
        wait_done({tag, "_done"});
        chk({tag, "_cnt"}, rx_q.size(), 9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            chk({tag, "_data"}, {24'd0, rx_q[i]}, 32'h31 + i);
            if (last_q[i]) lasts++;
        end
        chk({tag, "_last9"}, {31'd0, (last_q.size() == 9) ? last_q[8] : 1'b0}, 32'd1);
        chk({tag, "_lastn"}, lasts, 1);
        chk({tag, "_crc"}, {31'd0, crc_err}, {31'd0, exp_crc});
        chk({tag, "_tok"}, {31'd0, token_err}, 32'd0);
        chk({tag, "_to"}, {31'd0, timeout_err}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_drain"}, {31'd0, done_with_valid}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_oval"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_odata"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_olast"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_errs"}, {29'd0, crc_err, token_err, timeout_err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst_a_in");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_a");
        sel = 1'b1;
        #1;
        chk_all_zero("rst_b");
        sel = 1'b0;
        @(posedge clk); #1;

        // 1: good block, CRC 0x31C3 over "123456789"
        run_good("t1", 8'hC3, 1'b0);

        // 2: corrupted CRC low byte
        run_good("t2", 8'hC4, CrcOn);

        // 3: bad token after two idle bytes
        clear_mon();
        pulse_start();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h05);
        in_valid = 1'b0;
        wait_done("t3_done");
        chk("t3_tok", {31'd0, token_err}, 32'd1);
        chk("t3_to", {31'd0, timeout_err}, 32'd0);
        chk("t3_novalid", {31'd0, seen_valid}, 32'd0);
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // 4: timeout after the 8th 0xFF, not the 7th
        clear_mon();
        pulse_start();
        repeat (7) send_byte(8'hFF);
        chk("t4_to7", {31'd0, timeout_err}, 32'd0);
        chk("t4_busy7", {31'd0, busy}, 32'd1);
        send_byte(8'hFF);
        in_valid = 1'b0;
        chk("t4_to8", {31'd0, timeout_err}, 32'd1);
        wait_done("t4_done");
        chk("t4_idle", {31'd0, busy}, 32'd0);
        chk("t4_tok", {31'd0, token_err}, 32'd0);

        // 5: 512 zero bytes with the sink stalled for 100 cycles
        sel = 1'b1;
        out_ready = 1'b0;
        clear_mon();
        fed = 0;
        pulse_start();
        fork
            begin
                send_byte(8'hFE);
                for (int i = 0; i < 512; i++) begin
                    send_byte(8'h00);
                    fed++;
                end
                send_byte(8'h00);
                send_byte(8'h00);
                in_valid = 1'b0;
            end
            begin
                repeat (100) @(negedge clk);
                chk("t5_inrdy", {31'd0, in_ready}, 32'd0);
                chk("t5_fill", fed, 16);
                chk("t5_nodone", done_cnt, 0);
                out_ready = 1'b1;
            end
        join
        wait_done("t5_done");
        begin
            int nz = 0;
            int lasts = 0;
            foreach (rx_q[i]) if (rx_q[i] != 8'h00) nz++;
            foreach (last_q[i]) if (last_q[i]) lasts++;
            chk("t5_cnt", rx_q.size(), 512);
            chk("t5_nonzero", nz, 0);
            chk("t5_lastn", lasts, 1);
            chk("t5_last511", {31'd0, (last_q.size() == 512) ? last_q[511] : 1'b0}, 32'd1);
        end
        chk("t5_crc", {31'd0, crc_err}, 32'd0);
        chk("t5_drain", {31'd0, done_with_valid}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        sel = 1'b0;
        #1;

        // 6: reset in the middle of DATA, then a clean block
        clear_mon();
        out_ready = 1'b0;
        pulse_start();
        send_byte(8'hFE);
        repeat (3) send_byte(8'h55);
        in_valid = 1'b0;
        chk("t6_pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("t6_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_nodone", done_cnt, 0);
        run_good("t6", 8'hC3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
